// File: rtl/video_timing_gen_if.sv
// Pixel request/return bus and DVI output bundle of video_timing_gen.
// master = timing generator, slave = pixel source plus DVI core.
interface video_timing_gen_if;
    logic        req_o;
    logic [11:0] x_o;
    logic [11:0] y_o;
    logic [7:0]  pix_r_i;
    logic [7:0]  pix_g_i;
    logic [7:0]  pix_b_i;
    logic        hsync_o;
    logic        vsync_o;
    logic        de_o;
    logic        frame_o;
    logic [7:0]  pix_r_o;
    logic [7:0]  pix_g_o;
    logic [7:0]  pix_b_o;

    modport master (
        output req_o, x_o, y_o,
        input  pix_r_i, pix_g_i, pix_b_i,
        output hsync_o, vsync_o, de_o, frame_o, pix_r_o, pix_g_o, pix_b_o
    );

    modport slave (
        input  req_o, x_o, y_o,
        output pix_r_i, pix_g_i, pix_b_i,
        input  hsync_o, vsync_o, de_o, frame_o, pix_r_o, pix_g_o, pix_b_o
    );
endinterface

// File: rtl/video_timing_gen.sv
// Video timing generator: h/v counters, pixel requests, LATENCY-matched sync/de pipeline.
// Optional colour-bar test pattern is enabled by defining TEST_PATTERN_EN.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int LATENCY  = 2
) (
    input  logic               clk_pix,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               pattern_sel_i,
    video_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {IDLE, RUN} state_t;

    // Internal timing bundle; all flags active-high
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fr;
        logic       pat;
        logic [2:0] bar;
    } tim_t;

    state_t      state, state_nxt;
    logic [11:0] h, v, h_nxt, v_nxt;
    logic        run, active, fr0;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            h     <= '0;
            v     <= '0;
        end else begin
            state <= state_nxt;
            h     <= h_nxt;
            v     <= v_nxt;
        end
    end

    // Leaving RUN is only allowed on the end-of-frame wrap, so frames are never torn
    always_comb begin
        state_nxt = state;
        h_nxt     = '0;
        v_nxt     = '0;
        if (state == IDLE) begin
            if (en_i) state_nxt = RUN;
        end else if (h != H_LAST) begin
            h_nxt = h + 12'd1;
            v_nxt = v;
        end else if (v != V_LAST) begin
            v_nxt = v + 12'd1;
        end else if (!en_i) begin
            state_nxt = IDLE;
        end
    end

    assign run    = (state == RUN);
    assign active = run && (h < H_ACT) && (v < V_ACT);
    assign fr0    = run && (h == '0) && (v == '0);

    assign vif.req_o = active;
    assign vif.x_o   = active ? h : '0;
    assign vif.y_o   = active ? v : '0;

    logic       pat0;
    logic [2:0] bar0;

`ifdef TEST_PATTERN_EN
    localparam int          BAR_PIX  = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
    localparam logic [11:0] BAR_LAST = 12'(BAR_PIX - 1);

    logic        pat_q;
    logic [2:0]  bar_q;
    logic [11:0] sub_q;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= 1'b0;
            bar_q <= '0;
            sub_q <= '0;
        end else begin
            if (fr0) pat_q <= pattern_sel_i;
            if (!run || h == H_LAST) begin
                bar_q <= '0;
                sub_q <= '0;
            end else if (sub_q == BAR_LAST) begin
                sub_q <= '0;
                if (bar_q != 3'd7) bar_q <= bar_q + 3'd1;
            end else begin
                sub_q <= sub_q + 12'd1;
            end
        end
    end

    // The select takes effect from the very first pixel of the frame that samples it
    assign pat0 = fr0 ? pattern_sel_i : pat_q;
    assign bar0 = bar_q;
`else
    logic unused_sel;
    assign unused_sel = pattern_sel_i;
    assign pat0       = 1'b0;
    assign bar0       = 3'd0;
`endif

    tim_t s0;
    tim_t dly [1:LATENCY];
    tim_t t;

    always_comb begin
        s0     = '0;
        s0.hs  = run && (h >= HS_BEG) && (h < HS_END);
        s0.vs  = run && (v >= VS_BEG) && (v < VS_END);
        s0.de  = active;
        s0.fr  = fr0;
        s0.pat = pat0;
        s0.bar = bar0;
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= LATENCY; i++) dly[i] <= '0;
        end else begin
            dly[1] <= s0;
            for (int i = 2; i <= LATENCY; i++) dly[i] <= dly[i-1];
        end
    end

    assign t = dly[LATENCY];

    // Output register: polarity applied here only
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            vif.hsync_o <= ~H_POL;
            vif.vsync_o <= ~V_POL;
            vif.de_o    <= 1'b0;
            vif.frame_o <= 1'b0;
            vif.pix_r_o <= '0;
            vif.pix_g_o <= '0;
            vif.pix_b_o <= '0;
        end else begin
            vif.hsync_o <= t.hs ^ ~H_POL;
            vif.vsync_o <= t.vs ^ ~V_POL;
            vif.de_o    <= t.de;
            vif.frame_o <= t.fr;
            if (!t.de) begin
                vif.pix_r_o <= '0;
                vif.pix_g_o <= '0;
                vif.pix_b_o <= '0;
            end else if (t.pat) begin
                vif.pix_r_o <= {8{t.bar[2]}};
                vif.pix_g_o <= {8{t.bar[1]}};
                vif.pix_b_o <= {8{t.bar[0]}};
            end else begin
                vif.pix_r_o <= vif.pix_r_i;
                vif.pix_g_o <= vif.pix_g_i;
                vif.pix_b_o <= vif.pix_b_i;
            end
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: 16x8 total raster, LATENCY 2, active-low syncs.
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    video_timing_gen_if vif ();

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .LATENCY(2)
    ) dut (
        .clk_pix(clk), .rst_n(rst_n), .en_i(en), .pattern_sel_i(sel), .vif(vif)
    );

    // Pixel source: returns data two cycles after the request, junk when not requested
    logic [7:0] r1, r2, g1, g2, b1, b2;
    always_ff @(posedge clk) begin
        r1 <= vif.req_o ? {vif.x_o[3:0], 4'h0} : 8'hEE;
        g1 <= vif.req_o ? {vif.y_o[3:0], vif.x_o[3:0]} : 8'hEE;
        b1 <= vif.req_o ? 8'h5A : 8'hEE;
        r2 <= r1;
        g2 <= g1;
        b2 <= b1;
    end
    assign vif.pix_r_i = r2;
    assign vif.pix_g_i = g2;
    assign vif.pix_b_i = b2;

`ifdef TEST_PATTERN_EN
    logic tp_en = 1'b0;
    video_timing_gen_if tp_if ();
    assign tp_if.pix_r_i = 8'h33;
    assign tp_if.pix_g_i = 8'h33;
    assign tp_if.pix_b_i = 8'h33;
    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .LATENCY(2)
    ) u_tp (
        .clk_pix(clk), .rst_n(rst_n), .en_i(tp_en), .pattern_sel_i(1'b1), .vif(tp_if)
    );
`endif

    int checks = 0;
    int errors = 0;
    int k = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    // {hs, vs, de, frame, req, any pixel nonzero}
    function automatic int idle_bits();
        return {26'd0, vif.hsync_o, vif.vsync_o, vif.de_o, vif.frame_o, vif.req_o,
                |{vif.pix_r_o, vif.pix_g_o, vif.pix_b_o}};
    endfunction

    typedef struct {
        int req, x, y, de, hs, vs, fr, r, g, b;
    } vec_t;
    vec_t vec [19];

    int de_cnt, vs_cnt, vs_first, fr_cnt, req_cnt;

    initial begin
        // First line after enable, k = cycles since the first RUN cycle
        vec[0]  = '{1, 0, 0, 0, 1, 1, 0,   0, 0,  0};
        vec[1]  = '{1, 1, 0, 0, 1, 1, 0,   0, 0,  0};
        vec[2]  = '{1, 2, 0, 0, 1, 1, 0,   0, 0,  0};
        vec[3]  = '{1, 3, 0, 1, 1, 1, 1,   0, 0, 90};
        vec[4]  = '{1, 4, 0, 1, 1, 1, 0,  16, 1, 90};
        vec[5]  = '{1, 5, 0, 1, 1, 1, 0,  32, 2, 90};
        vec[6]  = '{1, 6, 0, 1, 1, 1, 0,  48, 3, 90};
        vec[7]  = '{1, 7, 0, 1, 1, 1, 0,  64, 4, 90};
        vec[8]  = '{0, 0, 0, 1, 1, 1, 0,  80, 5, 90};
        vec[9]  = '{0, 0, 0, 1, 1, 1, 0,  96, 6, 90};
        vec[10] = '{0, 0, 0, 1, 1, 1, 0, 112, 7, 90};
        vec[11] = '{0, 0, 0, 0, 1, 1, 0,   0, 0,  0};
        vec[12] = '{0, 0, 0, 0, 1, 1, 0,   0, 0,  0};
        vec[13] = '{0, 0, 0, 0, 0, 1, 0,   0, 0,  0};
        vec[14] = '{0, 0, 0, 0, 0, 1, 0,   0, 0,  0};
        vec[15] = '{0, 0, 0, 0, 0, 1, 0,   0, 0,  0};
        vec[16] = '{1, 0, 1, 0, 1, 1, 0,   0, 0,  0};
        vec[17] = '{1, 1, 1, 0, 1, 1, 0,   0, 0,  0};
        vec[18] = '{1, 2, 1, 0, 1, 1, 0,   0, 0,  0};

        repeat (3) @(negedge clk);
        chk("reset_state", idle_bits(), 6'b110000);
        chk("reset_xy", {vif.x_o, vif.y_o}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle[%0d]", i), idle_bits(), 6'b110000);
        end

        en = 1'b1;
        step();
        k = 0;
        for (int i = 0; i < 19; i++) begin
            chk($sformatf("req[k=%0d]", i), vif.req_o, vec[i].req);
            chk($sformatf("x[k=%0d]", i), vif.x_o, vec[i].x);
            chk($sformatf("y[k=%0d]", i), vif.y_o, vec[i].y);
            chk($sformatf("de[k=%0d]", i), vif.de_o, vec[i].de);
            chk($sformatf("hs[k=%0d]", i), vif.hsync_o, vec[i].hs);
            chk($sformatf("vs[k=%0d]", i), vif.vsync_o, vec[i].vs);
            chk($sformatf("frame[k=%0d]", i), vif.frame_o, vec[i].fr);
            chk($sformatf("r[k=%0d]", i), vif.pix_r_o, vec[i].r);
            chk($sformatf("g[k=%0d]", i), vif.pix_g_o, vec[i].g);
            chk($sformatf("b[k=%0d]", i), vif.pix_b_o, vec[i].b);
            step();
        end

        // Rest of frame 1 output window (k 19..130)
        de_cnt = 0; vs_cnt = 0; vs_first = -1; fr_cnt = 0;
        while (k < 131) begin
            de_cnt += int'(vif.de_o);
            fr_cnt += int'(vif.frame_o);
            if (!vif.vsync_o) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = k;
            end
            step();
        end
        chk("f1_de_cnt", de_cnt, 24);
        chk("f1_vs_cnt", vs_cnt, 32);
        chk("f1_vs_first", vs_first, 83);
        chk("f1_no_frame", fr_cnt, 0);
        chk("frame_period", vif.frame_o, 1);

        // Frame 2: drop en at v=2, frame must complete, then IDLE
        de_cnt = 0; vs_cnt = 0; fr_cnt = 0; req_cnt = 0;
        while (k < 271) begin
            de_cnt += int'(vif.de_o);
            fr_cnt += int'(vif.frame_o);
            vs_cnt += int'(!vif.vsync_o);
            if (k == 160) begin
                chk("en_drop_y", vif.y_o, 2);
                en = 1'b0;
            end
            if (k >= 256) req_cnt += int'(vif.req_o);
            if (k == 259) chk("drain_inactive", idle_bits(), 6'b110000);
            step();
        end
        chk("f2_de_cnt", de_cnt, 32);
        chk("f2_vs_cnt", vs_cnt, 32);
        chk("f2_frame_cnt", fr_cnt, 1);
        chk("idle_req_cnt", req_cnt, 0);

        // Reset mid-line
        en = 1'b1;
        step();
        repeat (5) step();
        chk("pre_rst_de", vif.de_o, 1);
        rst_n = 1'b0;
        #1;
        chk("midline_rst", idle_bits(), 6'b110000);
        chk("midline_rst_xy", {vif.x_o, vif.y_o}, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", idle_bits(), 6'b110000);

`ifdef TEST_PATTERN_EN
        begin
            logic [23:0] cols [8];
            cols = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                     24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
            tp_en = 1'b1;
            @(negedge clk);
            repeat (3) @(negedge clk);
            for (int p = 0; p < 16; p++) begin
                chk($sformatf("tp_de[%0d]", p), tp_if.de_o, 1);
                chk($sformatf("tp_rgb[%0d]", p),
                    {tp_if.pix_r_o, tp_if.pix_g_o, tp_if.pix_b_o}, cols[p/2]);
                @(negedge clk);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Pixel-clock video timing generator sitting directly upstream of the DVI/TMDS output core.
- Produces hsync/vsync/de plus RGB aligned for the encoders.
- Issues pixel requests (x, y) to a pixel source such as a framebuffer reader, which returns data a fixed number of cycles later.
- Delays the sync/de pipeline to match that return latency, so the output bundle is cycle-aligned.

Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vsync width, lines
- V_BP, 33: vertical back porch, lines
- H_POL, 0: hsync active level (0 = active-low)
- V_POL, 0: vsync active level (0 = active-low)
- LATENCY, 2: pixel source cycles from req_o to valid pix_*_i, range 1..15

Ports:
- clk_pix  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- en_i  in  1  run enable
- pattern_sel_i  in  1  select test pattern (used only with TEST_PATTERN_EN)
- req_o  out  1  pixel request, high in active area
- x_o  out  12  requested column, valid when req_o
- y_o  out  12  requested line, valid when req_o
- pix_r_i  in  8  pixel red, valid LATENCY cycles after req_o
- pix_g_i  in  8  pixel green
- pix_b_i  in  8  pixel blue
- hsync_o  out  1  horizontal sync to DVI core
- vsync_o  out  1  vertical sync to DVI core
- de_o  out  1  display enable to DVI core
- pix_r_o  out  8  red to DVI core
- pix_g_o  out  8  green to DVI core
- pix_b_o  out  8  blue to DVI core
- frame_o  out  1  one-cycle pulse on first output pixel of each frame

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1), 12 bits each.
- h increments every clk_pix while running and wraps to 0. v increments on each h wrap and wraps to 0 after V_TOTAL-1.
- Active area: h<H_ACTIVE and v<V_ACTIVE.
- hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync equivalently on v. Vsync edges coincide with h=0.
- Request stage is combinational from the counters: req_o = active; x_o = h, y_o = v when active, else 0.
- Delay line of LATENCY stages carries hsync, vsync, de, frame flag (h=0,v=0) and test-pattern bar index.
- Output register: one stage. All outputs appear LATENCY+1 cycles after the corresponding counter state.
- pix_*_o = pix_*_i registered when delayed de=1, else 0.
- States: IDLE (counters held 0, req_o 0) and RUN.
  - IDLE->RUN when en_i=1; first RUN cycle has h=0, v=0.
  - RUN->IDLE only at the end-of-frame wrap (h=H_TOTAL-1, v=V_TOTAL-1) with en_i=0. Deasserting en_i mid-frame completes the frame; no torn frames.
- In IDLE, the delay line shifts inactive values, so outputs drain to inactive after LATENCY+1 cycles.
- Reset (async assert, sync release by the system):
  - counters 0, state IDLE, whole delay line inactive;
  - hsync_o = ~H_POL, vsync_o = ~V_POL;
  - de_o, frame_o, req_o, x_o, y_o, pix_*_o all 0.
- Reset mid-frame takes effect immediately, with no frame completion.
- Sync polarity is applied only at the output register. Internal pipeline signals are active-high.

Optional Feature:
- Macro: TEST_PATTERN_EN.
- Defined: when pattern_sel_i=1, pix_*_o shows 8 vertical colour bars and ignores pix_*_i.
  - Bar index b = 0..7 comes from a bar counter reset at h=0. It advances every H_ACTIVE/8 pixels, saturates at 7, and is carried through the delay line.
  - Colour: R=8'hFF if b[2], G=8'hFF if b[1], B=8'hFF if b[0], else 0. b=0 is black, b=7 white.
  - pattern_sel_i is sampled at frame start only.
- Undefined: no bar logic; pattern_sel_i unused; output always follows pix_*_i.

Test Plan:
- Bench parameters: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), LATENCY 2, polarities 0.
- Reset with en_i=0 for 20 cycles -> hsync_o=1, vsync_o=1, de_o=0, req_o=0, pix_*_o=0 throughout.
- en_i=1 at cycle T -> req_o high T..T+7 with x_o=0..7, y_o=0; de_o high T+3..T+10; frame_o pulse at T+3; hsync_o low for 3 cycles starting T+13.
- Source returns pix_r_i=x_o*16 after 2 cycles -> pix_r_o=0,16,..,112 during de_o of line 0; 0 in blanking.
- Full frame -> exactly 32 de_o cycles; vsync_o low for 32 cycles starting 3 cycles after v=5,h=0; frame period 128 cycles.
- en_i dropped at v=2 -> frame completes to v=7,h=15, then IDLE, outputs inactive 3 cycles later; rst_n pulsed mid-line -> outputs reset values in the same cycle.
- TEST_PATTERN_EN with H_ACTIVE=16, pattern_sel_i=1 -> pix_*_o pairs black, blue, green, cyan, red, magenta, yellow, white, each for 2 pixels.
